// File: rtl/jtvigil_gfxarb_if.sv
// Bundles the three graphics requesters and the shared SDRAM read port.
// master = the arbiter, slave = the requesters / SDRAM controller side.
interface jtvigil_gfxarb_if;
    logic        scr1_cs;
    logic [16:0] scr1_addr;
    logic [31:0] scr1_data;
    logic        scr1_ok;

    logic        scr2_cs;
    logic [17:0] scr2_addr;
    logic [31:0] scr2_data;
    logic        scr2_ok;

    logic        obj_cs;
    logic [17:0] obj_addr;
    logic [31:0] obj_data;
    logic        obj_ok;

    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [31:0] sdram_din;

    modport master (
        input  scr1_cs, scr1_addr, scr2_cs, scr2_addr, obj_cs, obj_addr,
        output scr1_data, scr1_ok, scr2_data, scr2_ok, obj_data, obj_ok,
        output sdram_req, sdram_addr,
        input  sdram_ack, sdram_rdy, sdram_din
    );

    modport slave (
        output scr1_cs, scr1_addr, scr2_cs, scr2_addr, obj_cs, obj_addr,
        input  scr1_data, scr1_ok, scr2_data, scr2_ok, obj_data, obj_ok,
        input  sdram_req, sdram_addr,
        output sdram_ack, sdram_rdy, sdram_din
    );
endinterface

// File: rtl/jtvigil_gfxarb.sv
// Three-channel graphics ROM arbiter: one-entry cache per channel, round-robin
// refill over a single shared SDRAM read port, one transaction in flight.
module jtvigil_gfxarb #(
    parameter logic [21:0] SCR1_OFFSET = 22'h00000,
    parameter logic [21:0] SCR2_OFFSET = 22'h08000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h10000
) (
    input  logic               clk,
    input  logic               rst_n,
    jtvigil_gfxarb_if.master   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [16:0] scr1_tag;
    logic [17:0] scr2_tag;
    logic [17:0] obj_tag;
    logic [2:0]  valid;
    logic [31:0] scr1_cache;
    logic [31:0] scr2_cache;
    logic [31:0] obj_cache;

    logic [1:0]  last_gnt;
    logic [1:0]  cur_ch;
    logic [17:0] cur_addr;
    logic [21:0] addr_reg;

    logic [2:0]  hit;
    logic [2:0]  pending;
    logic        gnt_found;
    logic [1:0]  gnt_ch;
    logic [17:0] gnt_addr;
    logic [21:0] gnt_offset;
    logic        sdram_req;
    logic        fill;

    assign hit[0] = valid[0] && (bus.scr1_addr == scr1_tag);
    assign hit[1] = valid[1] && (bus.scr2_addr == scr2_tag);
    assign hit[2] = valid[2] && (bus.obj_addr  == obj_tag);

    // ok is forced low during reset so a stale hit never leaks through the reset cycle
    assign bus.scr1_ok = rst_n & bus.scr1_cs & hit[0];
    assign bus.scr2_ok = rst_n & bus.scr2_cs & hit[1];
    assign bus.obj_ok  = rst_n & bus.obj_cs  & hit[2];

    assign pending = {bus.obj_cs & ~hit[2], bus.scr2_cs & ~hit[1], bus.scr1_cs & ~hit[0]};

    assign bus.scr1_data  = scr1_cache;
    assign bus.scr2_data  = scr2_cache;
    assign bus.obj_data   = obj_cache;
    assign bus.sdram_req  = sdram_req;
    assign bus.sdram_addr = addr_reg;

    // Round-robin: search starts at the channel after the last one granted
    always_comb begin
        gnt_found  = |pending;
        gnt_ch     = 2'd0;
        gnt_addr   = 18'd0;
        gnt_offset = 22'd0;
        case (last_gnt)
            2'd0:    gnt_ch = pending[1] ? 2'd1 : (pending[2] ? 2'd2 : 2'd0);
            2'd1:    gnt_ch = pending[2] ? 2'd2 : (pending[0] ? 2'd0 : 2'd1);
            default: gnt_ch = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);
        endcase
        case (gnt_ch)
            2'd0: begin
                gnt_addr   = {1'b0, bus.scr1_addr};
                gnt_offset = SCR1_OFFSET;
            end
            2'd1: begin
                gnt_addr   = bus.scr2_addr;
                gnt_offset = SCR2_OFFSET;
            end
            default: begin
                gnt_addr   = bus.obj_addr;
                gnt_offset = OBJ_OFFSET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = REQ;
            REQ:     if (bus.sdram_ack) state_nxt = bus.sdram_rdy ? IDLE : WAIT;
            WAIT:    if (bus.sdram_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (state == REQ);
        fill      = ((state == REQ) && bus.sdram_ack && bus.sdram_rdy) ||
                    ((state == WAIT) && bus.sdram_rdy);
    end

    // The fill tags with the address latched at grant, not the live request address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt   <= 2'd2;
            cur_ch     <= 2'd0;
            cur_addr   <= 18'd0;
            addr_reg   <= 22'd0;
            valid      <= 3'b000;
            scr1_tag   <= 17'd0;
            scr2_tag   <= 18'd0;
            obj_tag    <= 18'd0;
            scr1_cache <= 32'd0;
            scr2_cache <= 32'd0;
            obj_cache  <= 32'd0;
        end else begin
            if ((state == IDLE) && gnt_found) begin
                last_gnt <= gnt_ch;
                cur_ch   <= gnt_ch;
                cur_addr <= gnt_addr;
                addr_reg <= gnt_offset + {4'd0, gnt_addr};
            end
            if (fill) begin
                case (cur_ch)
                    2'd0: begin
                        scr1_tag   <= cur_addr[16:0];
                        scr1_cache <= bus.sdram_din;
                        valid[0]   <= 1'b1;
                    end
                    2'd1: begin
                        scr2_tag   <= cur_addr;
                        scr2_cache <= bus.sdram_din;
                        valid[1]   <= 1'b1;
                    end
                    default: begin
                        obj_tag    <= cur_addr;
                        obj_cache  <= bus.sdram_din;
                        valid[2]   <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtvigil_gfxarb.sv
// Self-checking bench for jtvigil_gfxarb: directed scenarios plus a randomized
// run checked against a transaction-level cache/arbitration model.
`timescale 1ns/1ps
module tb_jtvigil_gfxarb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    jtvigil_gfxarb_if bus();

    jtvigil_gfxarb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Reference model: per-channel cache entry plus the one outstanding transfer
    bit          m_valid [3];
    logic [17:0] m_tag   [3];
    logic [31:0] m_data  [3];
    int          m_last;
    bit          m_busy;
    bit          m_acked;
    int          m_ch;
    logic [17:0] m_addr;
    logic [21:0] m_sdaddr;

    function automatic logic [21:0] offset(int c);
        case (c)
            0:       return 22'h00000;
            1:       return 22'h08000;
            default: return 22'h10000;
        endcase
    endfunction

    function automatic logic in_cs(int c);
        case (c)
            0:       return bus.scr1_cs;
            1:       return bus.scr2_cs;
            default: return bus.obj_cs;
        endcase
    endfunction

    function automatic logic [17:0] in_addr(int c);
        case (c)
            0:       return {1'b0, bus.scr1_addr};
            1:       return bus.scr2_addr;
            default: return bus.obj_addr;
        endcase
    endfunction

    function automatic logic out_ok(int c);
        case (c)
            0:       return bus.scr1_ok;
            1:       return bus.scr2_ok;
            default: return bus.obj_ok;
        endcase
    endfunction

    function automatic logic [31:0] out_data(int c);
        case (c)
            0:       return bus.scr1_data;
            1:       return bus.scr2_data;
            default: return bus.obj_data;
        endcase
    endfunction

    function automatic bit cached(int c);
        return m_valid[c] && (m_tag[c] == in_addr(c));
    endfunction

    function automatic logic exp_ok(int c);
        return rst_n && in_cs(c) && cached(c);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_valid[c] = 1'b0;
            m_tag[c]   = 18'd0;
            m_data[c]  = 32'd0;
        end
        m_last   = 2;
        m_busy   = 1'b0;
        m_acked  = 1'b0;
        m_ch     = 0;
        m_addr   = 18'd0;
        m_sdaddr = 22'd0;
    endtask

    task automatic model_fill();
        m_valid[m_ch] = 1'b1;
        m_tag[m_ch]   = m_addr;
        m_data[m_ch]  = bus.sdram_din;
        m_busy        = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_busy) begin
            if (!m_acked) begin
                if (bus.sdram_ack) begin
                    if (bus.sdram_rdy) model_fill();
                    else               m_acked = 1'b1;
                end
            end else if (bus.sdram_rdy) begin
                model_fill();
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int c = (m_last + k) % 3;
                if (!m_busy && in_cs(c) && !cached(c)) begin
                    m_busy   = 1'b1;
                    m_acked  = 1'b0;
                    m_ch     = c;
                    m_addr   = in_addr(c);
                    m_last   = c;
                    m_sdaddr = offset(c) + {4'd0, m_addr};
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_ch(int c, logic cs, logic [17:0] addr);
        case (c)
            0: begin bus.scr1_cs = cs; bus.scr1_addr = addr[16:0]; end
            1: begin bus.scr2_cs = cs; bus.scr2_addr = addr; end
            default: begin bus.obj_cs = cs; bus.obj_addr = addr; end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) drive_ch(c, 1'b0, 18'd0);
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        bus.sdram_din = 32'd0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (bus.sdram_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_ch(0, 1'b1, 18'h00010);
        drive_ch(1, 1'b1, 18'h00200);
        drive_ch(2, 1'b1, 18'h03000);
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = 32'hFFFF_FFFF;
        tick();
        tick();
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_ok(c) !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_ok ch%0d: got %b expected 0", c, out_ok(c));
            end
            n_cmp++;
            if (out_data(c) !== 32'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_data ch%0d: got %h expected 00000000", c, out_data(c));
            end
        end
        n_cmp++;
        if (bus.sdram_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_req: got %b expected 0", bus.sdram_req);
        end
        n_cmp++;
        if (bus.sdram_addr !== 22'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_addr: got %h expected 000000", bus.sdram_addr);
        end
        rst_n = 1'b1;
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_ok(c) !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL unfilled_ok ch%0d: got %b expected 0", c, out_ok(c));
            end
        end
        tick();
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00010) begin
            n_fail++;
            $display("[TB] FAIL first_priority: got req=%b addr=%h expected req=1 addr=000010",
                     bus.sdram_req, bus.sdram_addr);
        end
        do_reset();
    endtask

    task automatic test_basic_miss();
        do_reset();
        drive_ch(0, 1'b1, 18'h00010);
        for (int c = 0; c < 14; c++) begin
            bus.sdram_ack = (c == 3);
            bus.sdram_rdy = (c == 7);
            bus.sdram_din = (c == 7) ? 32'hDEADBEEF : 32'h0;
            #1;
            n_cmp++;
            if (bus.sdram_req !== (c >= 1 && c <= 3)) begin
                n_fail++;
                $display("[TB] FAIL miss_req c%0d: got %b expected %b", c, bus.sdram_req, (c >= 1 && c <= 3));
            end
            n_cmp++;
            if (bus.scr1_ok !== (c >= 8)) begin
                n_fail++;
                $display("[TB] FAIL miss_ok c%0d: got %b expected %b", c, bus.scr1_ok, (c >= 8));
            end
            if (c >= 1 && c <= 7) begin
                n_cmp++;
                if (bus.sdram_addr !== 22'h00010) begin
                    n_fail++;
                    $display("[TB] FAIL miss_addr c%0d: got %h expected 000010", c, bus.sdram_addr);
                end
            end
            if (c >= 8) begin
                n_cmp++;
                if (bus.scr1_data !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("[TB] FAIL miss_data c%0d: got %h expected deadbeef", c, bus.scr1_data);
                end
            end
            tick();
        end
        bus.sdram_rdy = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [21:0] exp_a [3] = '{22'h00000, 22'h08000, 22'h10000};
        bit seen;
        do_reset();
        for (int c = 0; c < 3; c++) drive_ch(c, 1'b1, 18'd0);
        for (int g = 0; g < 3; g++) begin
            wait_req(8, seen);
            n_cmp++;
            if (!seen) begin
                n_fail++;
                $display("[TB] FAIL rr_req_timeout g%0d: got no req expected req", g);
            end
            n_cmp++;
            if (bus.sdram_addr !== exp_a[g]) begin
                n_fail++;
                $display("[TB] FAIL rr_order g%0d: got %h expected %h", g, bus.sdram_addr, exp_a[g]);
            end
            bus.sdram_ack = 1'b1;
            bus.sdram_rdy = 1'b1;
            bus.sdram_din = 32'hA0A0_0000 + 32'(g);
            tick();
            bus.sdram_ack = 1'b0;
            bus.sdram_rdy = 1'b0;
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_ok(c) !== 1'b1 || out_data(c) !== 32'hA0A0_0000 + 32'(c)) begin
                n_fail++;
                $display("[TB] FAIL rr_fill ch%0d: got ok=%b data=%h expected ok=1 data=%h",
                         c, out_ok(c), out_data(c), 32'hA0A0_0000 + 32'(c));
            end
        end
    endtask

    task automatic test_fairness();
        bit seen;
        int ch;
        int run = 0;
        int obj_grants = 0;
        do_reset();
        drive_ch(0, 1'b1, 18'($urandom % 32'h8000));
        drive_ch(2, 1'b1, 18'($urandom % 32'h8000));
        for (int g = 0; g < 100; g++) begin
            wait_req(8, seen);
            if (!seen) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL fair_req_timeout g%0d: got no req expected req", g);
                break;
            end
            ch = (bus.sdram_addr >= 22'h10000) ? 2 : ((bus.sdram_addr >= 22'h08000) ? 1 : 0);
            n_cmp++;
            if (ch != m_ch) begin
                n_fail++;
                $display("[TB] FAIL fair_grant g%0d: got ch%0d expected ch%0d", g, ch, m_ch);
            end
            run = (ch == 2) ? 0 : run + 1;
            if (ch == 2) obj_grants++;
            n_cmp++;
            if (run > 1) begin
                n_fail++;
                $display("[TB] FAIL fair_starve g%0d: got %0d grants without obj expected <=1", g, run);
            end
            drive_ch(ch, 1'b1, (in_addr(ch) + 18'(1 + $urandom % 100)) & 18'h07FFF);
            for (int k = $urandom % 3; k > 0; k--) tick();
            bus.sdram_ack = 1'b1;
            if ($urandom % 4 == 0) begin
                bus.sdram_rdy = 1'b1;
                bus.sdram_din = $urandom;
                tick();
            end else begin
                tick();
                bus.sdram_ack = 1'b0;
                for (int k = $urandom % 4; k > 0; k--) tick();
                bus.sdram_rdy = 1'b1;
                bus.sdram_din = $urandom;
                tick();
            end
            bus.sdram_ack = 1'b0;
            bus.sdram_rdy = 1'b0;
        end
        n_cmp++;
        if (obj_grants < 50) begin
            n_fail++;
            $display("[TB] FAIL fair_obj_count: got %0d expected >=50", obj_grants);
        end
    endtask

    task automatic test_addr_change();
        bit seen;
        do_reset();
        drive_ch(1, 1'b1, 18'h00100);
        wait_req(8, seen);
        n_cmp++;
        if (!seen || bus.sdram_addr !== 22'h08100) begin
            n_fail++;
            $display("[TB] FAIL chg_first_req: got req=%b addr=%h expected req=1 addr=008100", seen, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        drive_ch(1, 1'b1, 18'h00200);
        tick();
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = 32'h1234_5678;
        tick();
        bus.sdram_rdy = 1'b0;
        #1;
        n_cmp++;
        if (bus.scr2_ok !== 1'b0 || bus.scr2_data !== 32'h1234_5678) begin
            n_fail++;
            $display("[TB] FAIL chg_stale_ok: got ok=%b data=%h expected ok=0 data=12345678", bus.scr2_ok, bus.scr2_data);
        end
        drive_ch(1, 1'b1, 18'h00100);
        #1;
        n_cmp++;
        if (bus.scr2_ok !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL chg_tag: got ok=%b expected 1 at old addr", bus.scr2_ok);
        end
        tick();
        drive_ch(1, 1'b1, 18'h00200);
        #1;
        n_cmp++;
        if (bus.scr2_ok !== 1'b0 || bus.sdram_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL chg_idle: got ok=%b req=%b expected ok=0 req=0", bus.scr2_ok, bus.sdram_req);
        end
        tick();
        wait_req(4, seen);
        n_cmp++;
        if (!seen || bus.sdram_addr !== 22'h08200) begin
            n_fail++;
            $display("[TB] FAIL chg_new_req: got req=%b addr=%h expected req=1 addr=008200", seen, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = 32'h0200_0200;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit seen;
        do_reset();
        drive_ch(0, 1'b1, 18'h00055);
        wait_req(8, seen);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_ch(0, 1'b0, 18'h00055);
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = 32'hBAD0_BAD0;
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b0 || bus.scr1_data !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL abort_state: got req=%b data=%h expected req=0 data=00000000", bus.sdram_req, bus.scr1_data);
        end
        tick();
        bus.sdram_rdy = 1'b0;
        drive_ch(0, 1'b1, 18'h00055);
        #1;
        n_cmp++;
        if (bus.scr1_ok !== 1'b0 || bus.scr1_data !== 32'd0 || bus.sdram_req !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_fill: got ok=%b data=%h req=%b expected ok=0 data=00000000 req=0",
                     bus.scr1_ok, bus.scr1_data, bus.sdram_req);
        end
        tick();
        wait_req(4, seen);
        n_cmp++;
        if (!seen || bus.sdram_addr !== 22'h00055) begin
            n_fail++;
            $display("[TB] FAIL abort_retry: got req=%b addr=%h expected req=1 addr=000055", seen, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = 32'h600D_600D;
        tick();
        bus.sdram_rdy = 1'b0;
        #1;
        n_cmp++;
        if (bus.scr1_ok !== 1'b1 || bus.scr1_data !== 32'h600D_600D) begin
            n_fail++;
            $display("[TB] FAIL abort_refill: got ok=%b data=%h expected ok=1 data=600d600d", bus.scr1_ok, bus.scr1_data);
        end
    endtask

    task automatic test_ack_rdy_same();
        bit seen;
        do_reset();
        drive_ch(2, 1'b1, 18'h00123);
        wait_req(8, seen);
        n_cmp++;
        if (!seen || bus.sdram_addr !== 22'h10123) begin
            n_fail++;
            $display("[TB] FAIL same_req: got req=%b addr=%h expected req=1 addr=010123", seen, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = 1'b1;
        bus.sdram_din = 32'hCAFE_F00D;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b0 || bus.obj_ok !== 1'b1 || bus.obj_data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("[TB] FAIL same_fill: got req=%b ok=%b data=%h expected req=0 ok=1 data=cafef00d",
                     bus.sdram_req, bus.obj_ok, bus.obj_data);
        end
        drive_ch(2, 1'b1, 18'h00124);
        tick();
        #1;
        n_cmp++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h10124) begin
            n_fail++;
            $display("[TB] FAIL same_idle: got req=%b addr=%h expected req=1 addr=010124", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom % 400 != 0);
            for (int c = 0; c < 3; c++) begin
                if ($urandom % 8 == 0) drive_ch(c, ($urandom % 4 != 0), in_addr(c));
                if ($urandom % 6 == 0) drive_ch(c, in_cs(c), 18'($urandom % 6));
            end
            bus.sdram_ack = m_busy && !m_acked && ($urandom % 3 == 0);
            bus.sdram_rdy = (m_busy && m_acked) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            bus.sdram_din = $urandom;
            #1;
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (out_ok(c) !== exp_ok(c)) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_ok cyc%0d ch%0d: got %b expected %b", cyc, c, out_ok(c), exp_ok(c));
                end
                n_cmp++;
                if (out_data(c) !== m_data[c]) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_data cyc%0d ch%0d: got %h expected %h", cyc, c, out_data(c), m_data[c]);
                end
            end
            n_cmp++;
            if (bus.sdram_req !== (m_busy && !m_acked)) begin
                n_fail++;
                $display("[TB] FAIL rnd_req cyc%0d: got %b expected %b", cyc, bus.sdram_req, (m_busy && !m_acked));
            end
            if (m_busy) begin
                n_cmp++;
                if (bus.sdram_addr !== m_sdaddr) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_addr cyc%0d: got %h expected %h", cyc, bus.sdram_addr, m_sdaddr);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int c = 0; c < 3; c++) drive_ch(c, 1'b0, 18'd0);
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        bus.sdram_din = 32'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_miss();
        test_round_robin();
        test_fairness();
        test_addr_change();
        test_reset_abort();
        test_ack_rdy_same();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
